// File: rtl/ldpc_bf_pkg.sv
// Shared constants and types for the LDPC bit-flipping decoder datapath,
// including the error-pattern generator and its LFSR.
package ldpc_bf_pkg;

  localparam int CW_LEN = 128;
  localparam int IDX_W  = 7;
  localparam int WGT_W  = 8;

  localparam logic [WGT_W-1:0] MAX_WGT = WGT_W'(CW_LEN);

  // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1 (state bits 15, 13, 12, 10).
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    DONE
  } gen_state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/error_pattern_gen_128_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous seed load; a zero seed is replaced
// by DEFAULT_SEED so the register can never lock up in the all-zero state.
module lfsr16
  import ldpc_bf_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] load_val;

  assign load_val = (seed == 16'h0000) ? DEFAULT_SEED : seed;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/error_pattern_gen_128.sv
// Generates a 128-bit error vector with an exact Hamming weight, one candidate
// bit per cycle. Optional codeword XOR output is enabled by ERR_INJECT_XOR_EN.
module error_pattern_gen_128
  import ldpc_bf_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WGT_W-1:0]  weight,
  input  logic              seed_load,
  input  logic [15:0]       seed,
`ifdef ERR_INJECT_XOR_EN
  input  logic [CW_LEN-1:0] codeword_in,
`endif
  output logic              busy,
  output logic              done,
  output logic [CW_LEN-1:0] pattern,
  output logic [WGT_W-1:0]  count
`ifdef ERR_INJECT_XOR_EN
  ,
  output logic [CW_LEN-1:0] corrupted
`endif
);

  gen_state_e        state_q, state_d;
  logic [WGT_W-1:0]  tgt_q, tgt_d;
  logic [CW_LEN-1:0] pattern_q, pattern_d;
  logic [WGT_W-1:0]  count_q, count_d;
  logic              probe_q, probe_d;
  logic [IDX_W-1:0]  prev_idx_q, prev_idx_d;

  logic [15:0]       lfsr_q;
  logic [15:0]       lfsr_nxt;
  logic              lfsr_en;
  logic              lfsr_load;
  logic [IDX_W-1:0]  cand_idx;
  logic [WGT_W-1:0]  weight_sat;
  logic [WGT_W-1:0]  count_inc;

  lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (lfsr_en),
    .load (lfsr_load),
    .seed (seed),
    .q    (lfsr_q)
  );

  assign lfsr_nxt   = lfsr_next(lfsr_q);
  assign weight_sat = (weight > MAX_WGT) ? MAX_WGT : weight;
  assign count_inc  = count_q + WGT_W'(1);

  // While probing, the LFSR is frozen and we walk linearly from the last hit.
  assign cand_idx = probe_q ? (prev_idx_q + IDX_W'(1)) : lfsr_nxt[IDX_W-1:0];

  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    pattern_d  = pattern_q;
    count_d    = count_q;
    probe_d    = probe_q;
    prev_idx_d = prev_idx_q;
    lfsr_en    = 1'b0;
    lfsr_load  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          tgt_d     = weight_sat;
          pattern_d = '0;
          count_d   = '0;
          probe_d   = 1'b0;
          if (weight_sat == '0) begin
            state_d = DONE;
          end else if (weight_sat == MAX_WGT) begin
            pattern_d = '1;
            count_d   = MAX_WGT;
            state_d   = DONE;
          end else begin
            state_d = GEN;
          end
        end else if (seed_load) begin
          lfsr_load = 1'b1;
        end
      end

      GEN: begin
        lfsr_en = ~probe_q;
        if (!pattern_q[cand_idx]) begin
          pattern_d[cand_idx] = 1'b1;
          count_d             = count_inc;
          probe_d             = 1'b0;
          if (count_inc == tgt_q) begin
            state_d = DONE;
          end
        end else begin
          probe_d    = 1'b1;
          prev_idx_d = cand_idx;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tgt_q      <= '0;
      pattern_q  <= '0;
      count_q    <= '0;
      probe_q    <= 1'b0;
      prev_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      pattern_q  <= pattern_d;
      count_q    <= count_d;
      probe_q    <= probe_d;
      prev_idx_q <= prev_idx_d;
    end
  end

  assign busy    = (state_q == GEN);
  assign done    = (state_q == DONE);
  assign pattern = pattern_q;
  assign count   = count_q;

`ifdef ERR_INJECT_XOR_EN
  logic [CW_LEN-1:0] cw_q, cw_d;
  logic [CW_LEN-1:0] corrupted_q;

  always_comb begin
    cw_d = cw_q;
    if (state_q == IDLE && start) begin
      cw_d = codeword_in;
    end
  end

  // Built from next-state values so corrupted tracks pattern cycle for cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cw_q        <= '0;
      corrupted_q <= '0;
    end else begin
      cw_q        <= cw_d;
      corrupted_q <= cw_d ^ pattern_d;
    end
  end

  assign corrupted = corrupted_q;
`endif

endmodule

// File: doc/error_pattern_gen_128.md
Name: error_pattern_gen_128

Overview:
- Sequential generator of 128-bit error patterns with an exact, requested Hamming weight.
- It is the weight-to-vector inverse of the 128-bit popcount adder used by the bit-flipping decoder.
- Drives channel-error injection in front of the LDPC BF decoder; its outputs are checkable by feeding pattern into the popcount adder.
- Randomness comes from a deterministic, seedable 16-bit LFSR, so benches are reproducible.

Parameters:
- CW_LEN, 128, codeword length; fixed at 128; index width 7.
- WGT_W, 8, width of weight and count fields (0..128).
- SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request one pattern; sampled only in IDLE.
- weight  input  8  requested number of ones; values >128 saturate to 128.
- seed_load  input  1  in IDLE, load seed into LFSR (0 is replaced by 16'hACE1); lower priority than start.
- seed  input  16  LFSR seed value.
- busy  output  1  high while in GEN.
- done  output  1  one-cycle pulse when pattern is complete.
- pattern  output  128  generated error vector; held from done until next accepted start.
- count  output  8  number of ones placed so far.

Behaviour:
- Reset values: all outputs 0; LFSR = SEED; state = IDLE; probe flag = 0.
- States: IDLE, GEN, DONE.
- IDLE + start (rising edge T):
  - latch tgt = min(weight,128); clear pattern and count.
  - tgt==0 -> DONE.
  - tgt==128 -> pattern all ones, count=128, -> DONE.
  - otherwise -> GEN.
  - done is therefore high in cycle T+1 for weights 0 and 128.
- start while busy, or in DONE: ignored.
- LFSR: Fibonacci form, x^16+x^14+x^13+x^11+1.
  - next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - Advances only in GEN cycles with probe==0.
- GEN, one candidate per cycle:
  - idx = probe ? (prev_idx+1) mod 128 : next[6:0].
  - pattern[idx]==0: set bit, count+1, probe=0; if count+1==tgt -> DONE.
  - pattern[idx]==1 (collision): probe=1, prev_idx=idx; no count change. Linear probing wraps 127->0.
- Latency: weight w with no collisions gives done in cycle T+w+1. Each collision adds 1 cycle. Worst case is bounded because probing finds a free bit within 127 steps.
- DONE: done=1 for exactly one cycle -> IDLE. pattern and count are held.
- Invariant at done: popcount(pattern)==count==tgt.
- Reset mid-GEN: immediate return to IDLE; pattern/count cleared; LFSR=SEED; no done pulse.

Optional Feature:
- Macro ERR_INJECT_XOR_EN.
- Defined:
  - adds input codeword_in[127:0], latched on accepted start.
  - adds output corrupted[127:0] = latched codeword ^ pattern, registered; reset 0.
  - corrupted is valid when done is high.
- Undefined: neither port exists; no added logic.

Decomposition:
- Package ldpc_bf_pkg holds:
  - CW_LEN=128, IDX_W=7, WGT_W=8;
  - LFSR tap constants;
  - DEFAULT_SEED=16'hACE1;
  - state enum typedef {IDLE,GEN,DONE}.
- One sub-module is natural: lfsr16, with ports clk, rst, en, load, seed, q. Its zero-seed substitution lives inside it.

Test Plan:
- weight=0, start -> done high next cycle; pattern=0; count=0; busy never high.
- seed_load seed=16'h0001, then weight=1 -> first candidate idx=2; pattern=128'h4; count=1; done 2 cycles after start.
- weight=128, and separately weight=200 -> pattern all ones; count=128; done next cycle.
- Sweep weight 1..127 with fixed seed -> popcount adder sum equals weight for every pattern; done exactly once per request; start pulses during busy ignored.
- Assert rst mid-GEN (weight=64, after 10 cycles) -> outputs 0 immediately. A following identical request reproduces the same pattern as a run from power-up with the same seed.
- With ERR_INJECT_XOR_EN, codeword_in=all ones, weight=3 -> corrupted has exactly 125 ones; corrupted ^ pattern = all ones.
